// File: rtl/pulse_monitor.sv
// Pulse period monitor: measures cycle distance between rising edges of pulse_in,
// tracks min/max, counts edges, flags timeouts and reports lock to a nominal period.
module pulse_monitor #(
    parameter int                WIDTH    = 16,
    parameter logic [WIDTH-1:0]  TIMEOUT  = 16'd65535,
    parameter logic [WIDTH-1:0]  EXPECTED = 16'd1000,
    parameter logic [WIDTH-1:0]  TOL      = 16'd2,
    parameter int                LOCK_N   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    input  logic             clear,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic [WIDTH-1:0] min_period,
    output logic [WIDTH-1:0] max_period,
    output logic [WIDTH-1:0] pulse_count,
    output logic             timeout,
    output logic             lock
);

    localparam int LW = (LOCK_N < 1) ? 1 : $clog2(LOCK_N + 1);
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_N);

    // Tolerance window in WIDTH+1 bits so neither bound can wrap.
    localparam logic [WIDTH:0] EXP_W = {1'b0, EXPECTED};
    localparam logic [WIDTH:0] TOL_W = {1'b0, TOL};
    localparam logic [WIDTH:0] MAX_W = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0] LO_W  = (EXP_W >= TOL_W) ? (EXP_W - TOL_W) : '0;
    localparam logic [WIDTH:0] HI_W  = ((EXP_W + TOL_W) > MAX_W) ? MAX_W : (EXP_W + TOL_W);

    typedef enum logic [1:0] {IDLE, MEASURE, TMO} state_t;

    state_t           state_q;
    logic             prev_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] period_q;
    logic             period_valid_q;
    logic [WIDTH-1:0] min_q;
    logic [WIDTH-1:0] max_q;
    logic             have_stats_q;
    logic [WIDTH-1:0] pulse_count_q;
    logic             timeout_q;
    logic [LW-1:0]    lock_cnt_q;
    logic             lock_q;

    logic             edge_evt;
    logic             in_tol;
    logic [WIDTH-1:0] pulse_count_d;
    logic [LW-1:0]    lock_cnt_d;

    always_comb begin
        edge_evt      = pulse_in & ~prev_q;
        in_tol        = ({1'b0, cnt_q} >= LO_W) && ({1'b0, cnt_q} <= HI_W);
        pulse_count_d = (pulse_count_q == '1) ? pulse_count_q : pulse_count_q + 1'b1;
        lock_cnt_d    = (lock_cnt_q == LOCK_MAX) ? lock_cnt_q : lock_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            prev_q         <= 1'b0;
            cnt_q          <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            min_q          <= '0;
            max_q          <= '0;
            have_stats_q   <= 1'b0;
            pulse_count_q  <= '0;
            timeout_q      <= 1'b0;
            lock_cnt_q     <= '0;
            lock_q         <= 1'b0;
        end else begin
            prev_q         <= pulse_in;
            period_valid_q <= 1'b0;
            if (clear) begin
                // A coincident edge is dropped; only the edge detector history survives.
                state_q       <= IDLE;
                cnt_q         <= '0;
                period_q      <= '0;
                min_q         <= '0;
                max_q         <= '0;
                have_stats_q  <= 1'b0;
                pulse_count_q <= '0;
                timeout_q     <= 1'b0;
                lock_cnt_q    <= '0;
                lock_q        <= 1'b0;
            end else begin
                if (edge_evt) begin
                    pulse_count_q <= pulse_count_d;
                end
                case (state_q)
                    IDLE: begin
                        if (edge_evt) begin
                            cnt_q   <= {{(WIDTH-1){1'b0}}, 1'b1};
                            state_q <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (edge_evt) begin
                            period_q       <= cnt_q;
                            period_valid_q <= 1'b1;
                            cnt_q          <= {{(WIDTH-1){1'b0}}, 1'b1};
                            if (!have_stats_q) begin
                                min_q        <= cnt_q;
                                max_q        <= cnt_q;
                                have_stats_q <= 1'b1;
                            end else begin
                                if (cnt_q < min_q) min_q <= cnt_q;
                                if (cnt_q > max_q) max_q <= cnt_q;
                            end
                            if (in_tol) begin
                                lock_cnt_q <= lock_cnt_d;
                                lock_q     <= (lock_cnt_d == LOCK_MAX);
                            end else begin
                                lock_cnt_q <= '0;
                                lock_q     <= 1'b0;
                            end
                        end else if (cnt_q == TIMEOUT) begin
                            state_q    <= TMO;
                            timeout_q  <= 1'b1;
                            lock_cnt_q <= '0;
                            lock_q     <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    TMO: begin
                        if (edge_evt) begin
                            timeout_q <= 1'b0;
                            cnt_q     <= {{(WIDTH-1){1'b0}}, 1'b1};
                            state_q   <= MEASURE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign min_period   = min_q;
    assign max_period   = max_q;
    assign pulse_count  = pulse_count_q;
    assign timeout      = timeout_q;
    assign lock         = lock_q;

endmodule

// File: doc/pulse_monitor.md
PULSE_MONITOR -- requirements
Module: pulse_monitor

Interface
REQ-001 The block SHALL run on one clock; reset is synchronous and active-high.
REQ-002 Parameter WIDTH, default 16, SHALL set the width of the counter and of all period outputs.
REQ-003 Parameter TIMEOUT, default 16'd65535, SHALL set the cycle count with no pulse that raises a timeout.
REQ-004 Parameter EXPECTED, default 16'd1000, SHALL set the nominal period in cycles.
REQ-005 Parameter TOL, default 16'd2, SHALL set the allowed +/- deviation from EXPECTED.
REQ-006 Parameter LOCK_N, default 4, SHALL set how many consecutive in-tolerance periods assert lock.
REQ-007 Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- pulse_in  in  1  pulse stream, synchronous to clk
- clear  in  1  synchronous restart of measurement and statistics
- period  out  WIDTH  last measured period, in cycles
- period_valid  out  1  one-cycle strobe when period updates
- min_period  out  WIDTH  smallest valid period since reset/clear
- max_period  out  WIDTH  largest valid period since reset/clear
- pulse_count  out  WIDTH  number of rising edges seen, saturating
- timeout  out  1  level; no pulse for TIMEOUT cycles
- lock  out  1  level; LOCK_N consecutive in-tolerance periods

Function
REQ-008 An edge event SHALL be pulse_in=1 while the registered previous pulse_in=0; a pulse held high several cycles SHALL count as one event.
REQ-009 The FSM SHALL have states IDLE, MEASURE and TMO; reset and clear SHALL enter IDLE.
REQ-010 IDLE: an edge event SHALL load cnt=1 and go to MEASURE; no period_valid.
REQ-011 MEASURE, no edge: cnt SHALL increment; when cnt==TIMEOUT the FSM SHALL go to TMO and assert timeout.
REQ-012 MEASURE, edge: period<=cnt, period_valid=1 for exactly one cycle, cnt<=1, stay in MEASURE.
REQ-013 Period SHALL equal the cycle distance between consecutive edge events, e.g. edges 5 cycles apart -> period=5.
REQ-014 TMO: timeout SHALL stay 1 and cnt SHALL hold; an edge event SHALL clear timeout, load cnt=1 and go to MEASURE without period_valid.
REQ-015 On the first period_valid after reset/clear, min_period and max_period SHALL both load period; after that they SHALL update by unsigned compare.
REQ-016 pulse_count SHALL increment on every edge event in any state and saturate at 2^WIDTH-1.
REQ-017 A period is in tolerance when EXPECTED-TOL <= period <= EXPECTED+TOL.
- Bounds SHALL be computed in WIDTH+1 bits.
- The lower bound SHALL saturate at 0 and the upper bound at 2^WIDTH-1.
REQ-018 Each in-tolerance period SHALL increment a lock counter, which saturates at LOCK_N.
- lock SHALL be 1 while the lock counter equals LOCK_N.
- An out-of-tolerance period or entry to TMO SHALL zero the lock counter and deassert lock on the same edge.
REQ-019 All outputs SHALL be registered; period, period_valid, the statistics and lock SHALL update on the clock edge that samples the event.
REQ-020 If clear and an edge event occur together, clear SHALL win: the edge is not counted, and previous-pulse_in still updates.
REQ-021 rst SHALL have priority over clear and over every other input.

Reset
REQ-022 On rst or clear, all outputs SHALL go to 0, the state SHALL go to IDLE, and cnt and the lock counter SHALL go to 0.
- rst SHALL also zero previous-pulse_in.
- A reset in mid-measurement SHALL discard the partial interval.

Verification
Bench parameters: WIDTH=16, TIMEOUT=20, EXPECTED=5, TOL=1, LOCK_N=3.
REQ-023 Single-cycle pulses every 5 cycles, 5 pulses -> 4 period_valid strobes, period=5, min=max=5, pulse_count=5, lock rises on the 3rd strobe.
REQ-024 Pulse intervals 5,7,4 -> periods 5,7,4; min=4, max=7; lock stays 0, because 7 zeroes the lock counter.
REQ-025 One pulse then none -> timeout=1 exactly 20 cycles after the edge; the next pulse clears timeout with no period_valid, and a following pulse 5 cycles later gives period=5.
REQ-026 pulse_in held high 10 cycles -> pulse_count +1 only, no extra period_valid.
REQ-027 clear coincident with a pulse edge while locked -> all outputs 0, state IDLE, pulse_count=0; the next two edges 5 apart give one strobe, period=5.
REQ-028 rst asserted mid-interval (cnt=3) -> outputs 0 next cycle; the first post-reset edge produces no strobe.
